// File: rtl/latch_ctrl_pkg.sv
// Shared types for the latch sequencing controller: op codes and FSM states.
package latch_ctrl_pkg;

  // Requester operation; the reserved code is executed as a write.
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_CLEAR = 2'b01,
    OP_SET   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  // Controller phases around each latch access.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SETUP = 2'b01,
    OPEN  = 2'b10,
    HOLD  = 2'b11
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 (wrapping)
// and reports the first requester found.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx
);

  // Walk offsets from farthest to nearest so the nearest active requester
  // after last_grant is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/latch_seq_ctrl.sv
// Shares one latch between NUM_REQ requesters. Each access runs
// SETUP (data stable) -> OPEN (one control high for GATE_CYC cycles) -> HOLD
// (controls low, readback checked, requester acknowledged).
module latch_seq_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int LAT_WIDTH = 4,
  parameter int NUM_REQ   = 4,
  parameter int GATE_CYC  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*LAT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic                         busy,
  output logic                         lat_gate,
  output logic                         lat_aclr,
  output logic                         lat_aset,
  output logic [LAT_WIDTH-1:0]         lat_data,
  input  logic [LAT_WIDTH-1:0]         lat_q
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GATE_CYC + 1);

  state_t               r_state;
  op_t                  r_op;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        r_last;
  logic [LAT_WIDTH-1:0] r_exp;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_gate;
  logic                 r_aclr;
  logic                 r_aset;
  logic [LAT_WIDTH-1:0] r_lat_data;

  logic                 w_grant_valid;
  logic [IW-1:0]        w_grant_idx;
  logic [1:0]           w_req_op   [NUM_REQ];
  logic [LAT_WIDTH-1:0] w_req_data [NUM_REQ];
  op_t                  w_win_op;
  logic [LAT_WIDTH-1:0] w_win_data;
  logic [LAT_WIDTH-1:0] w_win_exp;

  // Unpack the flat request buses into per-requester fields.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_op[gi]   = req_op[2*gi +: 2];
    assign w_req_data[gi] = req_data[gi*LAT_WIDTH +: LAT_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req),
    .last_grant  (r_last),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // Winner's op/data and the value the latch must read back after the access.
  always_comb begin
    w_win_op   = op_t'(w_req_op[w_grant_idx]);
    w_win_data = w_req_data[w_grant_idx];
    case (w_win_op)
      OP_CLEAR: w_win_exp = '0;
      OP_SET:   w_win_exp = '1;
      default:  w_win_exp = w_win_data;
    endcase
  end

  // Sequencing FSM with phase counter; every output is registered so the
  // latch controls are glitch-free and only ever high in OPEN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_WRITE;
      r_idx      <= '0;
      r_last     <= IW'(NUM_REQ - 1);
      r_exp      <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_gate     <= 1'b0;
      r_aclr     <= 1'b0;
      r_aset     <= 1'b0;
      r_lat_data <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_idx      <= w_grant_idx;
            r_last     <= w_grant_idx;
            r_op       <= w_win_op;
            r_exp      <= w_win_exp;
            r_lat_data <= w_win_data;
            r_busy     <= 1'b1;
            r_state    <= SETUP;
          end
        end
        SETUP: begin
          r_gate  <= (r_op == OP_WRITE) || (r_op == OP_RSVD);
          r_aclr  <= (r_op == OP_CLEAR);
          r_aset  <= (r_op == OP_SET);
          r_cnt   <= CW'(GATE_CYC);
          r_state <= OPEN;
        end
        OPEN: begin
          if (r_cnt == CW'(1)) begin
            r_gate  <= 1'b0;
            r_aclr  <= 1'b0;
            r_aset  <= 1'b0;
            // Latch has been driven for GATE_CYC cycles with stable data;
            // its output is settled here.
            r_ack   <= NUM_REQ'(1) << r_idx;
            r_err   <= (lat_q != r_exp);
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        HOLD: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign lat_gate = r_gate;
  assign lat_aclr = r_aclr;
  assign lat_aset = r_aset;
  assign lat_data = r_lat_data;

endmodule

// File: tb/tb_latch_seq_ctrl.sv
// Bench: two controllers (GATE_CYC=1 and GATE_CYC=3) share one stimulus stream,
// each driving its own behavioural latch; a transaction-timeline model predicts
// every output on every cycle, plus literal checks of the directed scenarios.
module tb_latch_seq_ctrl;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n    = 1'b0;
  logic [N-1:0]     req      = '0;
  logic [2*N-1:0]   req_op   = '0;
  logic [N*W-1:0]   req_data = '0;
  logic             force_q0 = 1'b0;

  logic [NI-1:0][N-1:0] ack_a;
  logic [NI-1:0]        err_a, busy_a, gate_a, aclr_a, aset_a;
  logic [NI-1:0][W-1:0] ldat_a, q_a;

  int vectors     = 0;
  int miscompares = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int G = (gi == 0) ? 1 : 3;
    logic [N-1:0] ack_l;
    logic         err_l, busy_l, gate_l, aclr_l, aset_l;
    logic [W-1:0] ldat_l;
    logic [W-1:0] q_lat;

    latch_seq_ctrl #(
      .LAT_WIDTH (W),
      .NUM_REQ   (N),
      .GATE_CYC  (G)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_op   (req_op),
      .req_data (req_data),
      .ack      (ack_l),
      .err      (err_l),
      .busy     (busy_l),
      .lat_gate (gate_l),
      .lat_aclr (aclr_l),
      .lat_aset (aset_l),
      .lat_data (ldat_l),
      .lat_q    (force_q0 ? '0 : q_lat)
    );

    // Behavioural latch: clear dominates set, set dominates gate.
    always_latch begin
      if (aclr_l)      q_lat = '0;
      else if (aset_l) q_lat = '1;
      else if (gate_l) q_lat = ldat_l;
    end

    assign ack_a[gi]  = ack_l;
    assign err_a[gi]  = err_l;
    assign busy_a[gi] = busy_l;
    assign gate_a[gi] = gate_l;
    assign aclr_a[gi] = aclr_l;
    assign aset_a[gi] = aset_l;
    assign ldat_a[gi] = ldat_l;
    assign q_a[gi]    = q_lat;
  end

  // Model: m_t = cycles since grant (-1 when idle); transaction is
  // setup at 1, controls at 2..G+1, ack at G+2.
  int         m_g    [NI] = '{1, 3};
  int         m_t    [NI] = '{-1, -1};
  int         m_win  [NI] = '{0, 0};
  int         m_last [NI] = '{N-1, N-1};
  logic [1:0] m_op   [NI] = '{2'd0, 2'd0};
  logic [W-1:0] m_ldat [NI] = '{4'h0, 4'h0};
  logic [W-1:0] m_exp  [NI] = '{4'h0, 4'h0};
  logic       m_err  [NI] = '{1'b0, 1'b0};

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_t[k] = -1; m_last[k] = N-1; m_ldat[k] = '0; m_err[k] = 1'b0;
      end else if (m_t[k] < 0) begin
        bit found;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
          int i;
          i = (m_last[k] + off) % N;
          if (!found && req[i]) begin
            found     = 1'b1;
            m_win[k]  = i;
            m_last[k] = i;
            m_op[k]   = req_op[2*i +: 2];
            m_ldat[k] = req_data[i*W +: W];
            m_exp[k]  = (m_op[k] == 2'd1) ? 4'h0 : (m_op[k] == 2'd2) ? 4'hF : m_ldat[k];
            m_t[k]    = 1;
          end
        end
      end else begin
        // Readback: the latch shows the expected value unless output is stuck at 0.
        if (m_t[k] == m_g[k] + 1) m_err[k] = force_q0 ? (m_exp[k] != 4'h0) : 1'b0;
        m_t[k] = m_t[k] + 1;
        if (m_t[k] > m_g[k] + 2) m_t[k] = -1;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      logic         ctl;
      logic [N-1:0] e_ack;
      logic [12:0]  exp_v, act_v;
      ctl   = (m_t[k] >= 2) && (m_t[k] <= m_g[k] + 1);
      e_ack = (m_t[k] == m_g[k] + 2) ? (4'b0001 << m_win[k]) : 4'b0000;
      exp_v = {e_ack,
               (m_t[k] == m_g[k] + 2) ? m_err[k] : 1'b0,
               m_t[k] >= 1,
               ctl && (m_op[k] == 2'd0 || m_op[k] == 2'd3),
               ctl && (m_op[k] == 2'd1),
               ctl && (m_op[k] == 2'd2),
               m_ldat[k]};
      act_v = {ack_a[k], err_a[k], busy_a[k], gate_a[k], aclr_a[k], aset_a[k], ldat_a[k]};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL model_cmp inst%0d @%0t: got {ack,err,busy,gate,aclr,aset,data}=%b, want %b",
                 k, $time, act_v, exp_v);
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_val);
    vectors++;
    if (act != exp_val) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp_val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] d);
    req_op[2*i +: 2]   = op;
    req_data[i*W +: W] = d;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_a != '0 && n < 20) begin
      cyc();
      n++;
    end
    chk("wait_idle_timeout", int'(busy_a != '0), 0);
  endtask

  // One transaction by requester i; req dropped right after the grant.
  // Reports per-instance ack value, err and latency (cycles from grant).
  task automatic run_one(input int i, input logic [1:0] op, input logic [W-1:0] d,
                         output logic [N-1:0] acks [NI], output logic errs [NI],
                         output int lat [NI]);
    for (int k = 0; k < NI; k++) begin acks[k] = '0; errs[k] = 1'b0; lat[k] = -1; end
    set_req(i, op, d);
    req = 4'b0001 << i;
    cyc();
    req = '0;
    for (int c = 2; c <= 8; c++) begin
      cyc();
      for (int k = 0; k < NI; k++)
        if (ack_a[k] != '0) begin acks[k] = ack_a[k]; errs[k] = err_a[k]; lat[k] = c; end
    end
  endtask

  initial begin
    logic [N-1:0] acks [NI];
    logic         errs [NI];
    int           lat  [NI];
    int           seq  [$];
    int           tms  [$];
    int           tms3 [$];

    // Reset state.
    do_reset();
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", int'(busy_a[k]), 0);
      chk("rst_ack", int'(ack_a[k]), 0);
      chk("rst_data", int'(ldat_a[k]), 0);
    end

    // Requester 2 writes 4'hA; cycle c counts from the grant edge.
    set_req(2, 2'b00, 4'hA);
    req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) req = '0;
      if (c == 1) chk("w_data_c1", int'(ldat_a[0]), 4'hA);
      chk("w_gate_g1", int'(gate_a[0]), int'(c == 2));
      chk("w_gate_g3", int'(gate_a[1]), int'(c >= 2 && c <= 4));
      chk("w_ack_g1", int'(ack_a[0]), (c == 3) ? 4 : 0);
      chk("w_ack_g3", int'(ack_a[1]), (c == 5) ? 4 : 0);
      if (c == 3) begin
        chk("w_err", int'(err_a[0]), 0);
        chk("w_q", int'(q_a[0]), 4'hA);
      end
    end

    // All four hold requests: round robin from requester 0.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b00, W'(i + 1));
    req = 4'hF;
    for (int c = 1; c <= 30; c++) begin
      cyc();
      if (ack_a[0] != '0) begin
        chk("rr_onehot", $countones(ack_a[0]), 1);
        for (int i = 0; i < N; i++) if (ack_a[0][i]) seq.push_back(i);
        tms.push_back(c);
      end
      if (ack_a[1] != '0) tms3.push_back(c);
    end
    req = '0;
    wait_idle();
    chk("rr_count", int'(seq.size() >= 5), 1);
    for (int j = 0; j < 5 && j < seq.size(); j++) chk("rr_order", seq[j], j % N);
    for (int j = 1; j < 5 && j < tms.size(); j++) chk("rr_spacing_g1", tms[j] - tms[j-1], 4);
    for (int j = 1; j < 3 && j < tms3.size(); j++) chk("rr_spacing_g3", tms3[j] - tms3[j-1], 6);

    // Clear, set, reserved op.
    run_one(1, 2'b01, 4'h9, acks, errs, lat);
    for (int k = 0; k < NI; k++) begin
      chk("clr_ack", int'(acks[k]), 2);
      chk("clr_q", int'(q_a[k]), 0);
    end
    run_one(3, 2'b10, 4'h0, acks, errs, lat);
    for (int k = 0; k < NI; k++) begin
      chk("set_ack", int'(acks[k]), 8);
      chk("set_q", int'(q_a[k]), 4'hF);
      chk("set_lat", lat[k], (k == 0) ? 3 : 5);
    end
    run_one(0, 2'b11, 4'h6, acks, errs, lat);
    for (int k = 0; k < NI; k++) begin
      chk("rsvd_q", int'(q_a[k]), 6);
      chk("rsvd_err", int'(errs[k]), 0);
    end

    // Readback stuck at zero.
    force_q0 = 1'b1;
    run_one(0, 2'b00, 4'h5, acks, errs, lat);
    for (int k = 0; k < NI; k++) chk("stuck_err5", int'(errs[k]), 1);
    run_one(0, 2'b00, 4'h0, acks, errs, lat);
    for (int k = 0; k < NI; k++) chk("stuck_err0", int'(errs[k]), 0);
    force_q0 = 1'b0;

    // Reset while OPEN.
    set_req(0, 2'b00, 4'h9);
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    chk("mid_open_gate", int'(gate_a), 3);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_gate", int'(gate_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_ack", int'(ack_a[0] | ack_a[1]), 0);
    rst_n = 1'b1;
    set_req(3, 2'b00, 4'h3);
    req = 4'b1001;
    begin
      int first;
      first = -1;
      for (int c = 1; c <= 8; c++) begin
        cyc();
        if (first < 0 && ack_a[0] != '0) first = int'(ack_a[0]);
      end
      chk("post_rst_winner", first, 1);
    end
    req = '0;
    wait_idle();

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 3) == 0) set_req(i, 2'($urandom), 4'($urandom));
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
      chk("never_aclr_aset", int'((aclr_a & aset_a) != '0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
